col_compress_multi: RTL and testbench

- Parallel compressive-sensing column engine. Accepts one sparse-counter value per beat (row order 0..NUM_COUNTER-1, slice after slice) and multiplies it against NUM_COL sensing-matrix columns at once, accumulating one inner product per column.
- Sensing matrix is runtime-loadable. Supports binary (0/1) and bipolar (±1) modes.
- Completed per-slice results are buffered in an output FIFO with a valid/ready handshake.
- Sits between the sparse-counter producer and the compressed-sketch store.

---
 rtl/col_compress_multi.sv | 179 +++++++++++++++++
 tb/tb_col_compress_multi.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/col_compress_multi.sv
// Compressive-sensing column engine: streams sparse-counter beats against NUM_COL
// runtime-loaded matrix columns and queues per-slice inner products in a FWFT FIFO.

module col_lane #(
  parameter int ACC_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             step_i,
  input  logic             bit_i,
  input  logic             mode_i,
  input  logic [ACC_W-1:0] term_i,
  output logic [ACC_W-1:0] sum_o
);
  logic [ACC_W-1:0] acc_q, acc_d, delta;

  always_comb begin
    if (bit_i)       delta = term_i;
    else if (mode_i) delta = -term_i;
    else             delta = '0;
    sum_o = acc_q + delta;
    acc_d = acc_q;
    if (clr_i)       acc_d = '0;
    else if (step_i) acc_d = sum_o;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) acc_q <= '0;
    else       acc_q <= acc_d;
  end
endmodule

module col_compress_multi #(
  parameter int NUM_COUNTER = 10,
  parameter int NUM_SLICE   = 2,
  parameter int NUM_COL     = 3,
  parameter int DATA_W      = 32,
  parameter int ACC_W       = 32,
  parameter int FIFO_DEPTH  = 4,
  localparam int COL_W      = (NUM_COL > 1) ? $clog2(NUM_COL) : 1
) (
  input  logic                     Clk_i,
  input  logic                     Reset_i,
  input  logic                     Mode_i,
  input  logic                     Mat_Wr_En_i,
  input  logic [COL_W-1:0]         Mat_Wr_Col_i,
  input  logic [NUM_COUNTER-1:0]   Mat_Wr_Data_i,
  input  logic                     Start_i,
  output logic                     Busy_o,
  output logic                     Done_o,
  input  logic                     In_Valid_i,
  output logic                     In_Ready_o,
  input  logic [DATA_W-1:0]        Spa_Counter_i,
  output logic                     Out_Valid_o,
  input  logic                     Out_Ready_i,
  output logic [7:0]               Out_Slice_o,
  output logic [NUM_COL*ACC_W-1:0] Out_Data_o
);
  localparam int RW = $clog2(NUM_COUNTER);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  typedef struct packed {
    logic [7:0]               slice;
    logic [NUM_COL*ACC_W-1:0] data;
  } res_t;

  state_t                              state_q, state_d;
  logic [RW-1:0]                       row_q, row_d;
  logic [7:0]                          slice_q, slice_d;
  logic                                mode_q, mode_d;
  logic [NUM_COL-1:0][NUM_COUNTER-1:0] mat_q, mat_d;
  res_t                                fifo_q [FIFO_DEPTH];
  logic [AW:0]                         wr_q, rd_q;

  logic                             last_row, accept, push, pop, full, empty, start_run;
  logic [NUM_COL-1:0]               lane_bit;
  logic [NUM_COL-1:0][ACC_W-1:0]    sum;
  logic [ACC_W-1:0]                 term;
  res_t                             head;

  assign last_row   = (row_q == RW'(NUM_COUNTER - 1));
  assign empty      = (wr_q == rd_q);
  assign full       = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  // Only the slice-closing beat needs FIFO room, so the stall is confined to that row.
  assign In_Ready_o = (state_q == S_ACCUM) && !(last_row && full);
  assign accept     = In_Valid_i && In_Ready_o;
  assign push       = accept && last_row;
  assign pop        = !empty && Out_Ready_i;
  assign start_run  = (state_q == S_IDLE) && Start_i;
  assign term       = ACC_W'(Spa_Counter_i);

  always_comb begin
    for (int c = 0; c < NUM_COL; c++) lane_bit[c] = mat_q[c][row_q];
  end

  col_lane #(.ACC_W(ACC_W)) u_lane [NUM_COL-1:0] (
    .clk_i  (Clk_i),
    .rst_i  (Reset_i),
    .clr_i  (start_run | push),
    .step_i (accept & ~last_row),
    .bit_i  (lane_bit),
    .mode_i (mode_q),
    .term_i (term),
    .sum_o  (sum)
  );

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    slice_d = slice_q;
    mode_d  = mode_q;
    mat_d   = mat_q;
    case (state_q)
      S_IDLE: begin
        for (int c = 0; c < NUM_COL; c++)
          if (Mat_Wr_En_i && (Mat_Wr_Col_i == COL_W'(c))) mat_d[c] = Mat_Wr_Data_i;
        if (Start_i) begin
          row_d   = '0;
          slice_d = '0;
          mode_d  = Mode_i;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (accept) begin
          if (last_row) begin
            row_d   = '0;
            slice_d = slice_q + 8'd1;
            if (slice_q == 8'(NUM_SLICE - 1)) state_d = S_DONE;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      slice_q <= '0;
      mode_q  <= 1'b0;
      mat_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      slice_q <= slice_d;
      mode_q  <= mode_d;
      mat_q   <= mat_d;
    end
  end

  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_q[AW-1:0]] <= '{slice: slice_q, data: sum};
        wr_q <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
    end
  end

  assign head        = fifo_q[rd_q[AW-1:0]];
  assign Out_Valid_o = !empty;
  assign Out_Slice_o = empty ? 8'd0 : head.slice;
  assign Out_Data_o  = empty ? '0 : head.data;
  assign Busy_o      = (state_q != S_IDLE);
  assign Done_o      = (state_q == S_DONE);
endmodule

// File: tb/tb_col_compress_multi.sv
// Bench for col_compress_multi: table of runs with hand-derived per-slice results,
// scoreboard queue checked at the output handshake, plus backpressure and reset sequences.

module tb_col_compress_multi;
  localparam int NC = 10, NS = 3, NCOL = 3, DW = 32, AW = 32, FD = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, mode, wr_en, start, in_valid, out_ready;
  logic [1:0]        wr_col;
  logic [NC-1:0]     wr_data;
  logic [DW-1:0]     spa;
  logic              busy, done, in_ready, out_valid;
  logic [7:0]        out_slice;
  logic [NCOL*AW-1:0] out_data;

  col_compress_multi #(
    .NUM_COUNTER(NC), .NUM_SLICE(NS), .NUM_COL(NCOL),
    .DATA_W(DW), .ACC_W(AW), .FIFO_DEPTH(FD)
  ) dut (
    .Clk_i(clk), .Reset_i(rst), .Mode_i(mode),
    .Mat_Wr_En_i(wr_en), .Mat_Wr_Col_i(wr_col), .Mat_Wr_Data_i(wr_data),
    .Start_i(start), .Busy_o(busy), .Done_o(done),
    .In_Valid_i(in_valid), .In_Ready_o(in_ready), .Spa_Counter_i(spa),
    .Out_Valid_o(out_valid), .Out_Ready_i(out_ready),
    .Out_Slice_o(out_slice), .Out_Data_o(out_data)
  );

  typedef logic [2:0][31:0] w3_t;
  typedef logic [2:0][9:0]  m3_t;
  typedef struct {
    bit                     mode;
    m3_t                    mat;
    w3_t                    base;   // per-slice: data[r] = base[s] + step[s]*r
    w3_t                    step;
    logic [2:0][2:0][31:0]  exp;    // [slice][col]
  } vec_t;
  typedef struct packed {
    logic [7:0]  slice;
    logic [95:0] data;
  } ent_t;

  ent_t q[$];
  vec_t vecs[4];
  int   tests = 0, fails = 0;

  function automatic w3_t mk(logic [31:0] a0, logic [31:0] a1, logic [31:0] a2);
    w3_t r; r[0] = a0; r[1] = a1; r[2] = a2; return r;
  endfunction
  function automatic m3_t mkm(logic [9:0] a0, logic [9:0] a1, logic [9:0] a2);
    m3_t r; r[0] = a0; r[1] = a1; r[2] = a2; return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      ent_t e;
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL out_unexpected: got slice %0d data %0h, none expected", out_slice, out_data);
      end else begin
        e = q.pop_front();
        if ({out_slice, out_data} !== e) begin
          fails++;
          $display("FAIL out_entry: got slice %0d data %0h expected slice %0d data %0h",
                   out_slice, out_data, e.slice, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic beat(input logic [31:0] v);
    int n;
    in_valid = 1'b1; spa = v; n = 0;
    @(negedge clk);
    while (!in_ready && n < 60) begin @(negedge clk); n++; end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL beat_timeout: in_ready=%0b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic load(input m3_t m);
    for (int c = 0; c < 3; c++) begin
      wr_en = 1'b1; wr_col = 2'(c); wr_data = m[c]; tick();
    end
    wr_col = 2'd3; wr_data = 10'h2AB; tick();
    wr_en = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 40 && q.size() != 0; n++) tick();
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic run_vec(input int v, input bit gaps, input bit noise, input bit late_col2);
    m3_t m;
    logic [31:0] val;
    m = vecs[v].mat;
    if (late_col2) m[2] = ~vecs[v].mat[2];
    load(m);
    mode = vecs[v].mode; start = 1'b1;
    if (late_col2) begin wr_en = 1'b1; wr_col = 2'd2; wr_data = vecs[v].mat[2]; end
    tick();
    start = 1'b0; wr_en = 1'b0; mode = ~vecs[v].mode;
    chk("busy_after_start", busy, 1);
    for (int s = 0; s < NS; s++) begin
      for (int r = 0; r < NC; r++) begin
        val = vecs[v].base[s] + vecs[v].step[s] * 32'(r);
        if (gaps) repeat ($urandom_range(0, 3)) tick();
        if (noise && r == 3) begin
          wr_en = 1'b1; wr_col = 2'd0; wr_data = NC'($urandom); start = 1'b1;
        end
        if (r == NC - 1) q.push_back('{slice: 8'(s), data: vecs[v].exp[s]});
        beat(val);
        wr_en = 1'b0; start = 1'b0;
      end
    end
    chk("done_pulse", {done, busy}, 2'b11);
    if (noise) start = 1'b1;
    tick();
    start = 1'b0;
    chk("done_clear", {done, busy, in_ready}, 3'b000);
    drain();
  endtask

  initial begin
    logic [31:0] val;
    rst = 1'b1; mode = 0; wr_en = 0; start = 0; in_valid = 0; out_ready = 1'b1;
    wr_col = '0; wr_data = '0; spa = '0;
    tick(); tick();
    chk("reset_flags", {busy, done, in_ready, out_valid}, 4'b0000);
    chk("reset_data", {out_slice, out_data}, '0);
    rst = 1'b0;
    tick();

    vecs[0].mode = 1'b0; vecs[0].mat = mkm(10'h3FF, 10'h1FF, 10'h000);
    vecs[0].base = mk(1, 100, 5); vecs[0].step = mk(1, 0, 2);
    vecs[0].exp[0] = mk(55, 45, 0);
    vecs[0].exp[1] = mk(1000, 900, 0);
    vecs[0].exp[2] = mk(140, 117, 0);

    vecs[1] = vecs[0]; vecs[1].mode = 1'b1;
    vecs[1].exp[0] = mk(55, 35, 32'hFFFFFFC9);
    vecs[1].exp[1] = mk(1000, 800, 32'hFFFFFC18);
    vecs[1].exp[2] = mk(140, 94, 32'hFFFFFF74);

    vecs[2].mode = 1'b0; vecs[2].mat = mkm(10'h3FF, 10'h001, 10'h200);
    vecs[2].base = mk(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF); vecs[2].step = mk(0, 0, 0);
    for (int s = 0; s < 3; s++) vecs[2].exp[s] = mk(32'hFFFFFFF6, 32'hFFFFFFFF, 32'hFFFFFFFF);

    vecs[3].mode = 1'b1; vecs[3].mat = mkm(10'h155, 10'h2AA, 10'h3FF);
    vecs[3].base = mk(1, 10, 0); vecs[3].step = mk(1, 0, 3);
    vecs[3].exp[0] = mk(32'hFFFFFFFB, 5, 55);
    vecs[3].exp[1] = mk(0, 0, 100);
    vecs[3].exp[2] = mk(32'hFFFFFFF1, 15, 135);

    run_vec(0, 0, 0, 0);
    run_vec(1, 0, 0, 0);
    run_vec(2, 1, 0, 0);
    run_vec(3, 1, 1, 1);
    run_vec(0, 1, 1, 0);

    // Backpressure: two-entry FIFO fills after slices 0 and 1; slice 2 stalls at row 9.
    out_ready = 1'b0;
    load(vecs[0].mat);
    mode = 1'b0; start = 1'b1; tick(); start = 1'b0;
    for (int s = 0; s < 2; s++)
      for (int r = 0; r < NC; r++) begin
        if (r == NC - 1) q.push_back('{slice: 8'(s), data: vecs[0].exp[s]});
        beat(vecs[0].base[s] + vecs[0].step[s] * 32'(r));
      end
    for (int r = 0; r < NC - 1; r++) beat(vecs[0].base[2] + vecs[0].step[2] * 32'(r));
    val = vecs[0].base[2] + vecs[0].step[2] * 32'(NC - 1);
    q.push_back('{slice: 8'd2, data: vecs[0].exp[2]});
    in_valid = 1'b1; spa = val;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("stall_in_ready", {in_ready, out_valid}, 2'b01);
    end
    @(posedge clk); #1;
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("one_pop", q.size(), 2);
    @(negedge clk);
    chk("resume_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_done", done, 1);
    out_ready = 1'b1;
    drain();

    // Reset mid-run with an entry already queued.
    out_ready = 1'b0;
    load(vecs[0].mat);
    mode = 1'b1; start = 1'b1; tick(); start = 1'b0;
    for (int r = 0; r < NC; r++) beat(32'(r + 1));
    chk("pre_reset_valid", out_valid, 1);
    for (int r = 0; r < 5; r++) beat(32'(r + 1));
    rst = 1'b1; tick();
    chk("mid_reset_flags", {busy, done, in_ready, out_valid}, 4'b0000);
    chk("mid_reset_data", {out_slice, out_data}, '0);
    rst = 1'b0; out_ready = 1'b1;
    mode = 1'b1; start = 1'b1; tick(); start = 1'b0;
    for (int s = 0; s < NS; s++)
      for (int r = 0; r < NC; r++) begin
        if (r == NC - 1)
          q.push_back('{slice: 8'(s), data: {32'hFFFFFFC9, 32'hFFFFFFC9, 32'hFFFFFFC9}});
        beat(32'(r + 1));
      end
    chk("post_reset_done", done, 1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
